// File: rtl/sersub_pkg.sv
// Shared types and limits for the bit-serial subtract controller.
package sersub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & (b | bin)) | (b & bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: one full_subtractor cell stepped LSB-first over WIDTH bits.
// Optional zero flag output is built when SERSUB_FLAGS_EN is defined.
//   state | meaning
//   IDLE  | waiting for start, last result held on diff/bout
//   SHIFT | one operand bit pair consumed per clock
//   DONE  | result valid, done pulsed for one cycle
module serial_subtractor_ctrl
    import sersub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERSUB_FLAGS_EN
    output logic             zero,
`endif
    output logic             bout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic             brw_q, brw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             cell_d, cell_bout;
    logic [WIDTH-1:0] res_cat;
`ifdef SERSUB_FLAGS_EN
    logic             zero_q, zero_d;
`endif

    full_subtractor u_cell (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .bin  (brw_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Newest cell output enters at the MSB; after WIDTH steps this is the full difference.
    assign res_cat = {cell_d, res_q};

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SERSUB_FLAGS_EN
        zero_d  = zero_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                res_d = res_cat[WIDTH-1:1];
                brw_d = cell_bout;
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    diff_d  = res_cat;
                    bout_d  = cell_bout;
`ifdef SERSUB_FLAGS_EN
                    zero_d  = (res_cat == '0);
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERSUB_FLAGS_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SERSUB_FLAGS_EN
            zero_q  <= zero_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERSUB_FLAGS_EN
    assign zero = zero_q;
`endif

endmodule
